// File: rtl/gsu_mem_bridge.sv
// GSU-side memory front end: arbitrates GSU ROM/RAM requests, maps them onto the
// shared physical SRAM layout and runs a req/ack cycle with the SRAM controller.
module gsu_mem_bridge (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] ROM_MASK,
    input  logic        SNES_ACTIVE,
    input  logic        GSU_ROM_REQ,
    input  logic [7:0]  GSU_ROM_BANK,
    input  logic [15:0] GSU_ROM_ADDR,
    output logic [7:0]  GSU_ROM_DATA,
    output logic        GSU_ROM_ACK,
    input  logic        GSU_RAM_REQ,
    input  logic        GSU_RAM_WE,
    input  logic        GSU_RAM_BANK,
    input  logic [15:0] GSU_RAM_ADDR,
    input  logic [7:0]  GSU_RAM_WDATA,
    output logic [7:0]  GSU_RAM_RDATA,
    output logic        GSU_RAM_ACK,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [23:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA,
    input  logic        MEM_ACK
);

    // RESP is the ack-issue cycle after MEM_ACK; FAKE is the same for out-of-range ROM.
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_FAKE, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        last_rom_q, last_rom_d;
    logic        port_ram_q, port_ram_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  rdata_cap_q, rdata_cap_d;
    logic [7:0]  rom_data_q, rom_data_d;
    logic [7:0]  ram_data_q, ram_data_d;
    logic        rom_ack_q, rom_ack_d;
    logic        ram_ack_q, ram_ack_d;

    logic        grant_ram;
    logic        rom_in_range;
    logic [23:0] rom_phys;

    always_comb begin
        // Tie goes to the port not granted last; a lone requester always wins.
        grant_ram    = GSU_RAM_REQ & (~GSU_ROM_REQ | last_rom_q);
        rom_in_range = ~GSU_ROM_BANK[7] & ~(GSU_ROM_BANK[6] & GSU_ROM_BANK[5]);
        if (GSU_ROM_BANK[7:6] == 2'b00)
            rom_phys = {3'b000, GSU_ROM_BANK[5:0], GSU_ROM_ADDR[14:0]} & ROM_MASK;
        else
            rom_phys = {3'b000, GSU_ROM_BANK[4:0], GSU_ROM_ADDR} & ROM_MASK;
    end

    always_comb begin
        state_d     = state_q;
        last_rom_d  = last_rom_q;
        port_ram_d  = port_ram_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_cap_d = rdata_cap_q;
        rom_data_d  = rom_data_q;
        ram_data_d  = ram_data_q;
        rom_ack_d   = 1'b0;
        ram_ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!SNES_ACTIVE && (GSU_ROM_REQ || GSU_RAM_REQ)) begin
                    if (grant_ram) begin
                        port_ram_d  = 1'b1;
                        last_rom_d  = 1'b0;
                        mem_addr_d  = {7'b1100000, GSU_RAM_BANK, GSU_RAM_ADDR};
                        mem_we_d    = GSU_RAM_WE;
                        mem_wdata_d = GSU_RAM_WDATA;
                        mem_req_d   = 1'b1;
                        state_d     = S_WAIT;
                    end else begin
                        port_ram_d  = 1'b0;
                        last_rom_d  = 1'b1;
                        mem_we_d    = 1'b0;
                        rdata_cap_d = 8'h00;
                        if (rom_in_range) begin
                            mem_addr_d = rom_phys;
                            mem_req_d  = 1'b1;
                            state_d    = S_WAIT;
                        end else begin
                            state_d    = S_FAKE;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (MEM_ACK) begin
                    rdata_cap_d = MEM_RDATA;
                    mem_req_d   = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP, S_FAKE: begin
                if (port_ram_q) begin
                    ram_ack_d = 1'b1;
                    if (!mem_we_q)
                        ram_data_d = rdata_cap_q;
                end else begin
                    rom_ack_d  = 1'b1;
                    rom_data_d = rdata_cap_q;
                end
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            last_rom_q  <= 1'b1;
            port_ram_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 24'h000000;
            mem_wdata_q <= 8'h00;
            rdata_cap_q <= 8'h00;
            rom_data_q  <= 8'h00;
            ram_data_q  <= 8'h00;
            rom_ack_q   <= 1'b0;
            ram_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_rom_q  <= last_rom_d;
            port_ram_q  <= port_ram_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_cap_q <= rdata_cap_d;
            rom_data_q  <= rom_data_d;
            ram_data_q  <= ram_data_d;
            rom_ack_q   <= rom_ack_d;
            ram_ack_q   <= ram_ack_d;
        end
    end

    assign MEM_REQ       = mem_req_q;
    assign MEM_WE        = mem_we_q;
    assign MEM_ADDR      = mem_addr_q;
    assign MEM_WDATA     = mem_wdata_q;
    assign GSU_ROM_DATA  = rom_data_q;
    assign GSU_ROM_ACK   = rom_ack_q;
    assign GSU_RAM_RDATA = ram_data_q;
    assign GSU_RAM_ACK   = ram_ack_q;

endmodule

// File: tb/tb_gsu_mem_bridge.sv
// Scoreboard bench for gsu_mem_bridge: expected memory cycles and GSU results are
// queued at stimulus time and checked when the bridge issues MEM_REQ / GSU acks.
module tb_gsu_mem_bridge;

    logic        CLK = 1'b0;
    logic        RST;
    logic [23:0] ROM_MASK;
    logic        SNES_ACTIVE;
    logic        GSU_ROM_REQ;
    logic [7:0]  GSU_ROM_BANK;
    logic [15:0] GSU_ROM_ADDR;
    logic [7:0]  GSU_ROM_DATA;
    logic        GSU_ROM_ACK;
    logic        GSU_RAM_REQ;
    logic        GSU_RAM_WE;
    logic        GSU_RAM_BANK;
    logic [15:0] GSU_RAM_ADDR;
    logic [7:0]  GSU_RAM_WDATA;
    logic [7:0]  GSU_RAM_RDATA;
    logic        GSU_RAM_ACK;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [23:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;
    logic        MEM_ACK;

    gsu_mem_bridge dut (
        .CLK(CLK), .RST(RST), .ROM_MASK(ROM_MASK), .SNES_ACTIVE(SNES_ACTIVE),
        .GSU_ROM_REQ(GSU_ROM_REQ), .GSU_ROM_BANK(GSU_ROM_BANK), .GSU_ROM_ADDR(GSU_ROM_ADDR),
        .GSU_ROM_DATA(GSU_ROM_DATA), .GSU_ROM_ACK(GSU_ROM_ACK),
        .GSU_RAM_REQ(GSU_RAM_REQ), .GSU_RAM_WE(GSU_RAM_WE), .GSU_RAM_BANK(GSU_RAM_BANK),
        .GSU_RAM_ADDR(GSU_RAM_ADDR), .GSU_RAM_WDATA(GSU_RAM_WDATA),
        .GSU_RAM_RDATA(GSU_RAM_RDATA), .GSU_RAM_ACK(GSU_RAM_ACK),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ram;
        logic [23:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits for MEM_REQ, answers it with MEM_ACK, then waits for a GSU ack.
    // Latencies are counted in clock edges; -1 means the bound expired.
    task automatic mem_cycle(input logic [7:0] rd, output int req_lat,
                             output logic [23:0] addr, output logic we,
                             output logic [7:0] wd, output int ack_lat,
                             output logic rom_ack, output logic ram_ack);
        req_lat = -1;
        ack_lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (MEM_REQ === 1'b1) begin
                req_lat = i;
                break;
            end
            tick();
        end
        addr    = MEM_ADDR;
        we      = MEM_WE;
        wd      = MEM_WDATA;
        rom_ack = 1'b0;
        ram_ack = 1'b0;
        if (req_lat < 0) return;
        MEM_RDATA = rd;
        MEM_ACK   = 1'b1;
        tick();
        MEM_ACK   = 1'b0;
        MEM_RDATA = 8'hEE;
        for (int i = 0; i < 6; i++) begin
            if (GSU_ROM_ACK === 1'b1 || GSU_RAM_ACK === 1'b1) begin
                ack_lat = i;
                break;
            end
            tick();
        end
        rom_ack = GSU_ROM_ACK;
        ram_ack = GSU_RAM_ACK;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (MEM_REQ !== 1'b0 || MEM_WE !== 1'b0 || MEM_ADDR !== 24'h0 || MEM_WDATA !== 8'h0 ||
            GSU_ROM_ACK !== 1'b0 || GSU_RAM_ACK !== 1'b0 || GSU_ROM_DATA !== 8'h0 ||
            GSU_RAM_RDATA !== 8'h0) begin
            n_err++;
            $display("FAIL reset_values: req=%b we=%b addr=%h wd=%h racks=%b%b rom=%h ram=%h required all zero",
                     MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, GSU_ROM_ACK, GSU_RAM_ACK,
                     GSU_ROM_DATA, GSU_RAM_RDATA);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_rom_low();
        exp_t e; int rl, al; logic [23:0] a; logic w, ra, aa; logic [7:0] wd;
        ROM_MASK = 24'h0FFFFF;
        GSU_ROM_BANK = 8'h01;
        GSU_ROM_ADDR = 16'h8123;
        GSU_ROM_REQ  = 1'b1;
        sb.push_back('{1'b0, 24'h008123, 1'b0, 8'h00, 8'h5A});
        mem_cycle(8'h5A, rl, a, w, wd, al, ra, aa);
        GSU_ROM_REQ = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (rl !== 1 || a !== e.addr || w !== e.we) begin
            n_err++;
            $display("FAIL rom_low_req: lat=%0d addr=%h we=%b required lat=1 addr=%h we=%b",
                     rl, a, w, e.addr, e.we);
        end
        n_cmp++;
        if (al !== 1 || ra !== 1'b1 || aa !== 1'b0 || GSU_ROM_DATA !== e.data) begin
            n_err++;
            $display("FAIL rom_low_ack: lat=%0d rom_ack=%b ram_ack=%b data=%h required lat=1 1 0 data=%h",
                     al, ra, aa, GSU_ROM_DATA, e.data);
        end
        tick();
        n_cmp++;
        if (GSU_ROM_ACK !== 1'b0) begin
            n_err++;
            $display("FAIL rom_ack_pulse: ack=%b required 0", GSU_ROM_ACK);
        end
    endtask

    task automatic test_rom_high();
        exp_t e; int rl, al; logic [23:0] a; logic w, ra, aa; logic [7:0] wd;
        logic [23:0] masks [2];
        masks[0] = 24'h0FFFFF;
        masks[1] = 24'h03FFFF;
        for (int i = 0; i < 2; i++) begin
            ROM_MASK = masks[i];
            GSU_ROM_BANK = 8'h45;
            GSU_ROM_ADDR = 16'h1234;
            GSU_ROM_REQ  = 1'b1;
            sb.push_back('{1'b0, (i == 0) ? 24'h051234 : 24'h011234, 1'b0, 8'h00, 8'h60 + 8'(i)});
            mem_cycle(8'h60 + 8'(i), rl, a, w, wd, al, ra, aa);
            GSU_ROM_REQ = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (rl !== 1 || a !== e.addr || al !== 1 || ra !== 1'b1 || GSU_ROM_DATA !== e.data) begin
                n_err++;
                $display("FAIL rom_high_%0d: lat=%0d addr=%h acklat=%0d ack=%b data=%h required 1 %h 1 1 %h",
                         i, rl, a, al, ra, GSU_ROM_DATA, e.addr, e.data);
            end
            tick();
        end
    endtask

    task automatic test_fake();
        ROM_MASK = 24'hFFFFFF;
        GSU_ROM_BANK = 8'h60;
        GSU_ROM_ADDR = 16'h0000;
        GSU_ROM_REQ  = 1'b1;
        tick();
        n_cmp++;
        if (MEM_REQ !== 1'b0 || GSU_ROM_ACK !== 1'b0) begin
            n_err++;
            $display("FAIL fake_edge0: mem_req=%b ack=%b required 0 0", MEM_REQ, GSU_ROM_ACK);
        end
        tick();
        n_cmp++;
        if (MEM_REQ !== 1'b0 || GSU_ROM_ACK !== 1'b1 || GSU_ROM_DATA !== 8'h00) begin
            n_err++;
            $display("FAIL fake_edge1: mem_req=%b ack=%b data=%h required 0 1 00",
                     MEM_REQ, GSU_ROM_ACK, GSU_ROM_DATA);
        end
        GSU_ROM_REQ = 1'b0;
        tick();
    endtask

    task automatic test_snes_stall();
        exp_t e; int rl, al; logic [23:0] a; logic w, ra, aa; logic [7:0] wd;
        logic leaked;
        SNES_ACTIVE  = 1'b1;
        GSU_ROM_BANK = 8'h00;
        GSU_ROM_ADDR = 16'h0777;
        GSU_ROM_REQ  = 1'b1;
        sb.push_back('{1'b0, 24'h000777, 1'b0, 8'h00, 8'h42});
        leaked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (MEM_REQ !== 1'b0) leaked = 1'b1;
        end
        n_cmp++;
        if (leaked !== 1'b0) begin
            n_err++;
            $display("FAIL snes_stall: mem_req rose while SNES_ACTIVE, required 0");
        end
        SNES_ACTIVE = 1'b0;
        mem_cycle(8'h42, rl, a, w, wd, al, ra, aa);
        GSU_ROM_REQ = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (rl !== 1 || a !== e.addr || ra !== 1'b1 || GSU_ROM_DATA !== e.data) begin
            n_err++;
            $display("FAIL snes_release: lat=%0d addr=%h ack=%b data=%h required 1 %h 1 %h",
                     rl, a, ra, GSU_ROM_DATA, e.addr, e.data);
        end
        tick();
    endtask

    task automatic test_arbitration();
        exp_t e; int rl, al; logic [23:0] a; logic w, ra, aa; logic [7:0] wd;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ROM_MASK      = 24'hFFFFFF;
        GSU_ROM_BANK  = 8'h02;
        GSU_ROM_ADDR  = 16'h0005;
        GSU_RAM_WE    = 1'b0;
        GSU_RAM_BANK  = 1'b0;
        GSU_RAM_ADDR  = 16'h0010;
        sb.push_back('{1'b1, 24'hC00010, 1'b0, 8'h00, 8'h11});
        sb.push_back('{1'b0, 24'h010005, 1'b0, 8'h00, 8'h22});
        sb.push_back('{1'b1, 24'hC00010, 1'b0, 8'h00, 8'h33});
        GSU_ROM_REQ = 1'b1;
        GSU_RAM_REQ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            mem_cycle(e.data, rl, a, w, wd, al, ra, aa);
            if (aa === 1'b1) GSU_RAM_REQ = 1'b0;
            if (ra === 1'b1) GSU_ROM_REQ = 1'b0;
            n_cmp++;
            if (rl !== 1 || a !== e.addr || aa !== e.ram || ra !== !e.ram ||
                (e.ram ? GSU_RAM_RDATA : GSU_ROM_DATA) !== e.data) begin
                n_err++;
                $display("FAIL arb_grant_%0d: lat=%0d addr=%h rom_ack=%b ram_ack=%b required ram=%b addr=%h data=%h",
                         i, rl, a, ra, aa, e.ram, e.addr, e.data);
            end
            tick();
            GSU_ROM_REQ = 1'b1;
            GSU_RAM_REQ = 1'b1;
        end
        GSU_ROM_REQ = 1'b0;
        GSU_RAM_REQ = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ram_write();
        exp_t e; int rl, al; logic [23:0] a; logic w, ra, aa; logic [7:0] wd;
        GSU_RAM_WE    = 1'b1;
        GSU_RAM_BANK  = 1'b1;
        GSU_RAM_ADDR  = 16'h0042;
        GSU_RAM_WDATA = 8'hA5;
        GSU_RAM_REQ   = 1'b1;
        sb.push_back('{1'b1, 24'hC10042, 1'b1, 8'hA5, 8'h33});
        mem_cycle(8'hD7, rl, a, w, wd, al, ra, aa);
        GSU_RAM_REQ = 1'b0;
        GSU_RAM_WE  = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (rl !== 1 || a !== e.addr || w !== e.we || wd !== e.wdata) begin
            n_err++;
            $display("FAIL ram_write_req: lat=%0d addr=%h we=%b wd=%h required 1 %h %b %h",
                     rl, a, w, wd, e.addr, e.we, e.wdata);
        end
        n_cmp++;
        if (al !== 1 || aa !== 1'b1 || GSU_RAM_RDATA !== e.data) begin
            n_err++;
            $display("FAIL ram_write_ack: lat=%0d ack=%b rdata=%h required 1 1 %h",
                     al, aa, GSU_RAM_RDATA, e.data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e; int rl, al; logic [23:0] a; logic w, ra, aa; logic [7:0] wd;
        logic stray;
        ROM_MASK     = 24'hFFFFFF;
        GSU_ROM_BANK = 8'h03;
        GSU_ROM_ADDR = 16'h0100;
        GSU_ROM_REQ  = 1'b1;
        tick();
        n_cmp++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== 24'h018100) begin
            n_err++;
            $display("FAIL rst_mid_wait: mem_req=%b addr=%h required 1 018100", MEM_REQ, MEM_ADDR);
        end
        RST = 1'b1;
        GSU_ROM_REQ = 1'b0;
        tick();
        RST = 1'b0;
        n_cmp++;
        if (MEM_REQ !== 1'b0 || MEM_ADDR !== 24'h0 || GSU_ROM_DATA !== 8'h0 || GSU_RAM_RDATA !== 8'h0) begin
            n_err++;
            $display("FAIL rst_mid_clear: mem_req=%b addr=%h rom=%h ram=%h required 0 000000 00 00",
                     MEM_REQ, MEM_ADDR, GSU_ROM_DATA, GSU_RAM_RDATA);
        end
        MEM_ACK   = 1'b1;
        MEM_RDATA = 8'h77;
        tick();
        MEM_ACK = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (GSU_ROM_ACK !== 1'b0 || GSU_RAM_ACK !== 1'b0 || MEM_REQ !== 1'b0) stray = 1'b1;
            tick();
        end
        n_cmp++;
        if (stray !== 1'b0) begin
            n_err++;
            $display("FAIL rst_late_ack: late MEM_ACK produced activity, required none");
        end
        GSU_ROM_REQ = 1'b1;
        sb.push_back('{1'b0, 24'h018100, 1'b0, 8'h00, 8'h9C});
        mem_cycle(8'h9C, rl, a, w, wd, al, ra, aa);
        GSU_ROM_REQ = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (rl !== 1 || a !== e.addr || ra !== 1'b1 || GSU_ROM_DATA !== e.data) begin
            n_err++;
            $display("FAIL rst_recover: lat=%0d addr=%h ack=%b data=%h required 1 %h 1 %h",
                     rl, a, ra, GSU_ROM_DATA, e.addr, e.data);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; ROM_MASK = 24'hFFFFFF; SNES_ACTIVE = 1'b0;
        GSU_ROM_REQ = 1'b0; GSU_ROM_BANK = 8'h00; GSU_ROM_ADDR = 16'h0000;
        GSU_RAM_REQ = 1'b0; GSU_RAM_WE = 1'b0; GSU_RAM_BANK = 1'b0;
        GSU_RAM_ADDR = 16'h0000; GSU_RAM_WDATA = 8'h00;
        MEM_RDATA = 8'h00; MEM_ACK = 1'b0;
        test_reset();
        test_rom_low();
        test_rom_high();
        test_fake();
        test_snes_stall();
        test_arbitration();
        test_ram_write();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gsu_mem_bridge.md
# gsu_mem_bridge

GSU-side memory front end for the SuperFX build. It takes the GSU core's ROM fetch and Game Pak RAM read/write requests and translates GSU bank/offset pairs into the same physical SRAM layout used for SNES accesses: ROM at 0x000000, Game Pak RAM at 0xC00000. It arbitrates between the two GSU ports, stalls while the SNES owns the memory bus, and runs a request/acknowledge cycle with the SRAM controller.

## Interface
Parameters
- none

Ports (clock and reset first)
- CLK  in  1  system clock; every register is clocked on its rising edge
- RST  in  1  reset, synchronous and active-high
- ROM_MASK  in  24  physical ROM address mask
- SNES_ACTIVE  in  1  SNES owns the memory bus this cycle; no new memory cycle may start
- GSU_ROM_REQ  in  1  ROM fetch request; level, held until GSU_ROM_ACK
- GSU_ROM_BANK  in  8  ROM bank (ROMBR)
- GSU_ROM_ADDR  in  16  ROM offset
- GSU_ROM_DATA  out  8  fetched byte; valid in the GSU_ROM_ACK cycle and held until the next ROM ack
- GSU_ROM_ACK  out  1  one-cycle completion pulse
- GSU_RAM_REQ  in  1  RAM request; level, held until GSU_RAM_ACK
- GSU_RAM_WE  in  1  1 = write
- GSU_RAM_BANK  in  1  bit 0 of RAMBR (0x70/0x71)
- GSU_RAM_ADDR  in  16  RAM offset
- GSU_RAM_WDATA  in  8  write data
- GSU_RAM_RDATA  out  8  read data; same validity rule as GSU_ROM_DATA
- GSU_RAM_ACK  out  1  one-cycle completion pulse
- MEM_REQ  out  1  memory cycle request; level, held until MEM_ACK
- MEM_WE  out  1  write strobe qualifier
- MEM_ADDR  out  24  physical address
- MEM_WDATA  out  8  write data
- MEM_RDATA  in  8  read data; valid with MEM_ACK
- MEM_ACK  in  1  one-cycle completion pulse from the SRAM controller

## Operation
- Address translation, applied to the address sampled at grant:
  - ROM bank 0x00-0x3F: {3'b000, BANK[5:0], ADDR[14:0]} & ROM_MASK. ADDR[15] is ignored.
  - ROM bank 0x40-0x5F: {3'b000, BANK[4:0], ADDR[15:0]} & ROM_MASK.
  - ROM bank 0x60-0xFF: out of range. No memory cycle is run; the access completes with data 0x00.
  - RAM: {7'b1100000, RAM_BANK, ADDR[15:0]}, i.e. 0xC00000-0xC1FFFF. Not masked.
- State machine: IDLE -> (WAIT | FAKE) -> DONE -> IDLE.
  - IDLE: if any REQ is high and SNES_ACTIVE is low, grant one port. Latch the port, address, WE and WDATA.
    - Out-of-range ROM bank goes to FAKE.
    - Otherwise go to WAIT with MEM_REQ=1.
  - WAIT: MEM_REQ, MEM_ADDR, MEM_WE and MEM_WDATA are held stable. When MEM_ACK=1: capture MEM_RDATA (reads only), drop MEM_REQ, pulse the granted port's ACK in the next cycle, go to DONE. SNES_ACTIVE is ignored once in WAIT.
  - FAKE: pulse GSU_ROM_ACK with GSU_ROM_DATA=0x00, go to DONE.
  - DONE: one dead cycle in which no grant is made. The requester drops REQ in its ACK cycle, so a stale REQ is never re-served.
- Arbitration:
  - Round-robin via a last-granted flag (reset value: ROM, so RAM wins the first tie).
  - Simultaneous requests go to the port not granted last.
  - A lone requester is always granted, whatever the flag.
- Writes: GSU_RAM_RDATA is left unchanged. The ACK still pulses.
- MEM_ACK outside WAIT is ignored.

## Timing
- Reset values: MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, both ACKs=0, both data outputs=0x00, state IDLE, last-granted=ROM.
- Reset mid-operation: all of the above take effect at the next edge and the in-flight access is abandoned. A MEM_ACK that arrives afterwards is ignored.
- Latency, with edge 0 the first edge at which REQ is sampled in IDLE and SNES_ACTIVE is low:
  - MEM_REQ is high after edge 0.
  - If MEM_ACK is sampled at edge k (k≥1), the GSU ACK and data are valid after edge k+1.
  - IDLE is re-entered after edge k+2.
  - Minimum REQ-to-ACK is 2 cycles; minimum back-to-back access period is 4 cycles.
- FAKE path: ACK is high after edge 1.
- While SNES_ACTIVE is high in IDLE, no grant is made and requests wait indefinitely.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- ROM_MASK=0x0FFFFF, ROM REQ bank 0x01 addr 0x8123 → MEM_ADDR=0x008123, MEM_WE=0. Then MEM_RDATA=0x5A with MEM_ACK → GSU_ROM_ACK pulse one cycle later with GSU_ROM_DATA=0x5A.
- ROM REQ bank 0x45 addr 0x1234 → MEM_ADDR=0x051234. With ROM_MASK=0x03FFFF → MEM_ADDR=0x011234.
- RAM write bank 1 addr 0x0042 data 0xA5 → MEM_ADDR=0xC10042, MEM_WE=1, MEM_WDATA=0xA5; GSU_RAM_ACK after MEM_ACK; GSU_RAM_RDATA unchanged.
- ROM and RAM REQ raised together, both re-raised after each ACK, three times → grant order RAM, ROM, RAM. SNES_ACTIVE high for 5 cycles with a REQ pending → MEM_REQ stays 0 until the cycle after SNES_ACTIVE falls.
- ROM REQ bank 0x60 → no MEM_REQ, GSU_ROM_ACK after edge 1 with data 0x00.
- RST asserted during WAIT → next cycle MEM_REQ=0 and state IDLE; a late MEM_ACK produces no GSU ACK.
